// File: rtl/pick_sweep_ctrl.sv
// pick_sweep_ctrl: frame-rate sweep controller for a rotating pick.
// Every frame_clk rising edge is synchronized into CLK and turned into a
// one-cycle tick. On each tick the held keycode selects the sweep state
// (IDLE / SWEEP_CW / SWEEP_CCW / HOLD), the rotation phase, or a return home.
// PickX then steps in the sweep direction, wrapping within [488,935].
//
// Ports:
//   CLK         - single clock, rising edge
//   Reset       - asynchronous, active-high reset
//   frame_clk   - vertical-sync strobe, asynchronous to CLK
//   keycode     - held USB HID key code, 0 = none
//   PickX       - sweep position, always in [488,935]
//   phaseShift  - rotation phase select, 0..2
//   moving      - high while sweeping CW or CCW
//   rot_settled - high once the downstream trig LUT has caught up with
//                 PickX/phaseShift
//
// Build option: define PICK_SWEEP_RAMP_EN to double the step after every
// RAMP_FRAMES consecutive ticks in one direction, saturating at 4*STEP.
module pick_sweep_ctrl #(
  parameter logic [9:0]  START_X     = 10'd600,
  parameter int unsigned STEP        = 1,
  parameter int unsigned RAMP_FRAMES = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] PickX,
  output logic [1:0] phaseShift,
  output logic       moving,
  output logic       rot_settled
);

  // The wrap logic assumes the largest step stays below the 448-wide window.
  if (RAMP_FRAMES == 0 || STEP == 0 || STEP * 4 >= 448) begin : g_bad_params
    $error("pick_sweep_ctrl: STEP must be in 1..111 and RAMP_FRAMES non-zero");
  end

  typedef enum logic [1:0] {IDLE, SWEEP_CW, SWEEP_CCW, HOLD} state_t;

  localparam logic [10:0] X_LO   = 11'd488;
  localparam logic [10:0] X_HI   = 11'd935;
  localparam logic [10:0] X_SPAN = 11'd448;
  localparam logic [10:0] STEP_B = 11'(STEP);

  state_t      state, state_n;
  logic        last_ccw, last_ccw_n;
  logic        sync1, sync2, sync_prev;
  logic [1:0]  sync_fill;
  logic        tick;
  logic [9:0]  x_n;
  logic [1:0]  ph_n;
  logic        changed;
  logic [1:0]  settle_cnt;
  logic [10:0] step_cur;
  logic [10:0] x_ext;

  // The edge detector is only trusted once the synchronizer and the history
  // flop hold real samples; otherwise a frame_clk already high at reset
  // release would look like a fresh rising edge.
  assign tick  = sync2 & ~sync_prev & (&sync_fill);
  assign x_ext = {1'b0, PickX};

`ifdef PICK_SWEEP_RAMP_EN
  localparam int unsigned CNT_W = $clog2(RAMP_FRAMES + 1);
  logic [1:0]       lvl, lvl_n, lvl_base;
  logic [CNT_W-1:0] fcnt, fcnt_n, fcnt_inc;
  logic             entry;
`endif

  always_comb begin
    state_n    = state;
    last_ccw_n = last_ccw;
    x_n        = PickX;
    ph_n       = phaseShift;
    step_cur   = STEP_B;
`ifdef PICK_SWEEP_RAMP_EN
    lvl_n    = lvl;
    fcnt_n   = fcnt;
    entry    = 1'b0;
    lvl_base = '0;
    fcnt_inc = '0;
`endif
    if (tick) begin
      unique case (keycode)
        8'h07: state_n = SWEEP_CW;
        8'h04: state_n = SWEEP_CCW;
        8'h2C: begin
          if (state == SWEEP_CW || state == SWEEP_CCW) state_n = HOLD;
          else if (state == HOLD) state_n = last_ccw ? SWEEP_CCW : SWEEP_CW;
        end
        8'h4A: begin
          state_n = IDLE;
          x_n     = START_X;
        end
        8'h1E: ph_n = 2'd0;
        8'h1F: ph_n = 2'd1;
        8'h20: ph_n = 2'd2;
        default: ;
      endcase

`ifdef PICK_SWEEP_RAMP_EN
      // Any state change into a sweep restarts the ramp at base step; this
      // tick already counts as the first of the new run.
      if (state_n == SWEEP_CW || state_n == SWEEP_CCW) begin
        entry    = (state_n != state);
        lvl_base = entry ? 2'd0 : lvl;
        fcnt_inc = (entry ? '0 : fcnt) + 1'b1;
        step_cur = STEP_B << lvl_base;
        if (fcnt_inc == CNT_W'(RAMP_FRAMES)) begin
          fcnt_n = '0;
          lvl_n  = (lvl_base == 2'd2) ? 2'd2 : lvl_base + 2'd1;
        end else begin
          fcnt_n = fcnt_inc;
          lvl_n  = lvl_base;
        end
      end else begin
        lvl_n  = '0;
        fcnt_n = '0;
      end
`endif

      // Movement follows the new state, so a direction change moves at once.
      if (state_n == SWEEP_CW) begin
        last_ccw_n = 1'b0;
        if (x_ext + step_cur > X_HI) x_n = 10'(x_ext + step_cur - X_SPAN);
        else                         x_n = 10'(x_ext + step_cur);
      end else if (state_n == SWEEP_CCW) begin
        last_ccw_n = 1'b1;
        if (x_ext < X_LO + step_cur) x_n = 10'(x_ext + X_SPAN - step_cur);
        else                         x_n = 10'(x_ext - step_cur);
      end
    end
    changed = (x_n != PickX) || (ph_n != phaseShift);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync_prev   <= 1'b0;
      sync_fill   <= '0;
      state       <= IDLE;
      last_ccw    <= 1'b0;
      PickX       <= START_X;
      phaseShift  <= '0;
      moving      <= 1'b0;
      rot_settled <= 1'b0;
      settle_cnt  <= 2'd2;
`ifdef PICK_SWEEP_RAMP_EN
      lvl         <= '0;
      fcnt        <= '0;
`endif
    end else begin
      sync1     <= frame_clk;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;
      state      <= state_n;
      last_ccw   <= last_ccw_n;
      PickX      <= x_n;
      phaseShift <= ph_n;
      moving     <= (state_n == SWEEP_CW) || (state_n == SWEEP_CCW);
`ifdef PICK_SWEEP_RAMP_EN
      lvl        <= lvl_n;
      fcnt       <= fcnt_n;
`endif
      // Low for two cycles after a change: LUT address register plus margin.
      if (changed) begin
        rot_settled <= 1'b0;
        settle_cnt  <= 2'd2;
      end else if (settle_cnt != 2'd0) begin
        settle_cnt  <= settle_cnt - 2'd1;
        rot_settled <= (settle_cnt == 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_pick_sweep_ctrl.sv
module tb_pick_sweep_ctrl;

  localparam int START = 600;
  localparam int STEPV = 1;
  localparam int RF    = 16;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] PickX;
  logic [1:0] phaseShift;
  logic       moving;
  logic       rot_settled;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 cw, 2 ccw, 3 hold.
  int m_pos, m_ph, m_mode, m_last, m_run;

  pick_sweep_ctrl #(
    .START_X(10'(START)),
    .STEP(STEPV),
    .RAMP_FRAMES(RF)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .keycode(keycode),
    .PickX(PickX),
    .phaseShift(phaseShift),
    .moving(moving),
    .rot_settled(rot_settled)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] key;
    int         x;
    int         ph;
    int         mv;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = START; m_ph = 0; m_mode = 0; m_last = 1; m_run = 0;
  endtask

  function automatic int m_step();
`ifdef PICK_SWEEP_RAMP_EN
    int lvl;
    lvl = (m_run - 1) / RF;
    if (lvl > 2) lvl = 2;
    return STEPV * (1 << lvl);
`else
    return STEPV;
`endif
  endfunction

  task automatic model_tick(input logic [7:0] k);
    int nm, d;
    nm = m_mode;
    case (k)
      8'h07: nm = 1;
      8'h04: nm = 2;
      8'h2C: if (m_mode == 1 || m_mode == 2) nm = 3; else if (m_mode == 3) nm = m_last;
      8'h4A: begin nm = 0; m_pos = START; end
      8'h1E: m_ph = 0;
      8'h1F: m_ph = 1;
      8'h20: m_ph = 2;
      default: ;
    endcase
    if (nm == 1 || nm == 2) begin
      m_run  = (nm == m_mode) ? m_run + 1 : 1;
      m_last = nm;
      d      = (nm == 1) ? m_step() : -m_step();
      m_pos  = 488 + (((m_pos - 488 + d) % 448) + 448) % 448;
    end else begin
      m_run = 0;
    end
    m_mode = nm;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_x"}, int'(PickX), m_pos);
    chk({tag, "_ph"}, int'(phaseShift), m_ph);
    chk({tag, "_moving"}, int'(moving), (m_mode == 1 || m_mode == 2) ? 1 : 0);
    chk({tag, "_settled"}, int'(rot_settled), 1);
  endtask

  // One full frame: strobe high 4 CLK, low 4 CLK; outputs have settled after.
  task automatic do_tick(input logic [7:0] k);
    keycode = k;
    @(negedge CLK) frame_clk = 1'b1;
    repeat (4) @(negedge CLK);
    frame_clk = 1'b0;
    repeat (4) @(negedge CLK);
    model_tick(k);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    model_reset();
  endtask

  initial begin
    int n, low;
    logic [9:0] prev;
    logic [7:0] k;

    vecs[0]  = '{8'h00, 600, 0, 0};
    vecs[1]  = '{8'h2C, 600, 0, 0};
    vecs[2]  = '{8'h07, 601, 0, 1};
    vecs[3]  = '{8'h07, 602, 0, 1};
    vecs[4]  = '{8'h1F, 603, 1, 1};
    vecs[5]  = '{8'h2C, 603, 1, 0};
    vecs[6]  = '{8'h2C, 604, 1, 1};
    vecs[7]  = '{8'h04, 603, 1, 1};
    vecs[8]  = '{8'h2C, 603, 1, 0};
    vecs[9]  = '{8'h2C, 602, 1, 1};
    vecs[10] = '{8'h20, 601, 2, 1};
    vecs[11] = '{8'h1E, 600, 0, 1};
    vecs[12] = '{8'h55, 599, 0, 1};
    vecs[13] = '{8'h4A, 600, 0, 0};
    vecs[14] = '{8'h00, 600, 0, 0};

    // Power-on reset and settle timing after release.
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_x", int'(PickX), 600);
    chk("rst_ph", int'(phaseShift), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_settled", int'(rot_settled), 0);
    Reset = 1'b0;
    @(negedge CLK);
    chk("rel_settled_1clk", int'(rot_settled), 0);
    @(negedge CLK);
    chk("rel_settled_2clk", int'(rot_settled), 1);
    model_reset();

    // Five idle ticks.
    for (int i = 0; i < 5; i++) do_tick(8'h00);
    chk("idle5_x", int'(PickX), 600);
    chk("idle5_ph", int'(phaseShift), 0);
    chk("idle5_moving", int'(moving), 0);
    chk("idle5_settled", int'(rot_settled), 1);

    // Table of key sequences.
    for (int i = 0; i < 15; i++) begin
      do_tick(vecs[i].key);
      chk($sformatf("vec%0d_x", i), int'(PickX), vecs[i].x);
      chk($sformatf("vec%0d_ph", i), int'(phaseShift), vecs[i].ph);
      chk($sformatf("vec%0d_moving", i), int'(moving), vecs[i].mv);
      chk($sformatf("vec%0d_settled", i), int'(rot_settled), 1);
    end

    // Wrap at the top of the window.
    reset_dut();
    for (int i = 0; i < 336; i++) do_tick(8'h07);
    check_model("cw336");
`ifndef PICK_SWEEP_RAMP_EN
    chk("cw336_const", int'(PickX), 488);
`endif
    do_tick(8'h07);
    check_model("cw337");
`ifndef PICK_SWEEP_RAMP_EN
    chk("cw337_const", int'(PickX), 489);
    do_tick(8'h04);
    chk("ccw_to_488", int'(PickX), 488);
`endif

    // Wrap at the bottom, tick latency and settle-low window.
    prev = PickX;
    keycode = 8'h04;
    @(negedge CLK) frame_clk = 1'b1;
    n = 0;
    while (PickX == prev && n < 10) begin @(negedge CLK); n++; end
    chk("tick_latency", n, 3);
    low = 0;
    while (!rot_settled && low < 10) begin low++; @(negedge CLK); end
    chk("settle_low_cycles", low, 2);
    frame_clk = 1'b0;
    repeat (4) @(negedge CLK);
    model_tick(8'h04);
    check_model("ccw_wrap");
`ifndef PICK_SWEEP_RAMP_EN
    chk("ccw_wrap_const", int'(PickX), 935);
`endif

    // Hold at 700 and resume.
    do_tick(8'h4A);
    n = 0;
    while (m_pos != 700 && n < 400) begin do_tick(8'h07); n++; end
    chk("reach_700", int'(PickX), 700);
    do_tick(8'h2C);
    chk("hold_x", int'(PickX), 700);
    chk("hold_moving", int'(moving), 0);
    do_tick(8'h00);
    chk("hold_stay_x", int'(PickX), 700);
    do_tick(8'h2C);
    chk("resume_x", int'(PickX), 701);
    chk("resume_moving", int'(moving), 1);

    // Phase select while sweeping, then reset mid-frame.
    do_tick(8'h1F);
    check_model("phase_sweep");
    chk("phase_sweep_step", int'(PickX), 702);
    keycode = 8'h07;
    @(negedge CLK) frame_clk = 1'b1;
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("async_rst_x", int'(PickX), 600);
    chk("async_rst_moving", int'(moving), 0);
    chk("async_rst_ph", int'(phaseShift), 0);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (8) @(negedge CLK);
    chk("high_at_release_x", int'(PickX), 600);
    chk("high_at_release_moving", int'(moving), 0);
    frame_clk = 1'b0;
    repeat (4) @(negedge CLK);
    model_reset();
    do_tick(8'h07);
    check_model("post_rst_tick");

`ifdef PICK_SWEEP_RAMP_EN
    do_tick(8'h4A);
    for (int i = 0; i < 64; i++) do_tick(8'h07);
    chk("ramp64_x", int'(PickX), 776);
    check_model("ramp64");
`endif

    // Randomized keys against the model.
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2:  k = 8'h07;
        3, 4, 5:  k = 8'h04;
        6:        k = 8'h2C;
        7:        k = 8'h1E + 8'($urandom_range(0, 2));
        8:        k = ($urandom_range(0, 3) == 0) ? 8'h4A : 8'h00;
        9:        k = 8'($urandom);
        default:  k = 8'h00;
      endcase
      do_tick(k);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pick_sweep_ctrl.md
PICK_SWEEP_CTRL -- requirements
Module: pick_sweep_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 10'd600, the reset/home sweep position.
REQ-002 SHALL have parameter STEP, default 1, the base position increment per frame.
REQ-003 SHALL have parameter RAMP_FRAMES, default 16, the frames per speed level (ramp builds only).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock. All flops are on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port frame_clk, input, 1 bit: vertical-sync frame strobe, asynchronous to CLK.
REQ-007 SHALL have port keycode, input, 8 bits: the currently held key (USB HID code); 0 means none.
REQ-008 SHALL have port PickX, output, 10 bits: the sweep position, always in [488,935].
REQ-009 SHALL have port phaseShift, output, 2 bits: the rotation phase select, always in {0,1,2}.
REQ-010 SHALL have port moving, output, 1 bit: high in SWEEP_CW or SWEEP_CCW.
REQ-011 SHALL have port rot_settled, output, 1 bit: high when the downstream trig-LUT result reflects the current PickX/phaseShift.

Function
REQ-012 SHALL pass frame_clk through a 2-flop synchronizer followed by a rising-edge detector, producing a 1-CLK tick exactly once per frame_clk rising edge.
REQ-013 SHALL implement the states IDLE, SWEEP_CW, SWEEP_CCW and HOLD.
REQ-014 SHALL sample keycode and update state/outputs only on tick cycles.
REQ-015 On tick, keycode 0x07 ('D') SHALL select SWEEP_CW and 0x04 ('A') SHALL select SWEEP_CCW, from any state.
REQ-016 On tick, keycode 0x2C (space) SHALL move SWEEP_* to HOLD, and HOLD to the direction last swept; in IDLE it SHALL be ignored.
REQ-017 On tick, keycode 0x4A (Home) SHALL load PickX=START_X and enter IDLE from any state.
REQ-018 On tick, keycode 0x1E/0x1F/0x20 ('1'/'2'/'3') SHALL set phaseShift to 0/1/2 with no state change.
REQ-019 On tick with any other keycode, or 0, the state SHALL be unchanged.
REQ-020 In SWEEP_CW each tick SHALL add the current step to PickX; in SWEEP_CCW each tick SHALL subtract it.
REQ-021 The update SHALL use the new state: a tick that changes the direction also moves in the new direction.
REQ-022 PickX SHALL wrap modulo 448 within [488,935]: 935+1 gives 488; 488-1 gives 935; for step>1 the excess carries over, e.g. 934+3 gives 489.
REQ-023 The sum SHALL be computed at least 11 bits wide, so there is no 10-bit overflow before the wrap.
REQ-024 In IDLE and HOLD, PickX SHALL be held.
REQ-025 rot_settled SHALL drop in the cycle after PickX or phaseShift changes.
REQ-026 rot_settled SHALL re-assert 2 CLK later (1 cycle for the LUT address register plus 1 margin) and stay high until the next change.
REQ-027 moving SHALL be registered and change in the same cycle as the state.

Reset
REQ-028 Reset high SHALL immediately force: state IDLE, PickX=START_X, phaseShift=0, moving=0, rot_settled=0, synchronizer flops=0, step level=base, frame counter=0.
REQ-029 After Reset release, rot_settled SHALL assert 2 CLK cycles later.
REQ-030 Reset mid-sweep SHALL abandon the pending tick; no position update occurs in the release cycle.
REQ-031 A frame_clk that is already high at Reset release SHALL not generate a tick.

Configuration
REQ-032 With macro PICK_SWEEP_RAMP_EN defined, the step SHALL start at STEP on entry to a SWEEP state.
REQ-033 With the ramp enabled, the step SHALL double after every RAMP_FRAMES consecutive ticks in the same direction, saturating at 4*STEP.
REQ-034 With the ramp enabled, the step SHALL reset to STEP on any change of direction, on HOLD, on IDLE, or on Reset.
REQ-035 Without PICK_SWEEP_RAMP_EN, the step SHALL be the constant STEP and there SHALL be no frame counter logic.

Verification
REQ-036 Reset, then 5 ticks with keycode 0: PickX=600, phaseShift=0, moving=0, rot_settled=1.
REQ-037 keycode 0x07 for 336 ticks from 600: PickX=936-448=488 after tick 336, then 489 after tick 337.
REQ-038 keycode 0x04 from PickX=488 for 1 tick: PickX=935; rot_settled low for exactly 2 CLK after the update.
REQ-039 Sweeping CW at 700, keycode 0x2C: HOLD, moving=0, PickX stays 700; second 0x2C resumes CW with 701 on that tick.
REQ-040 keycode 0x1F while sweeping: phaseShift=1, PickX still steps; Reset asserted mid-frame sets PickX=600 within the same cycle, asynchronously.
REQ-041 With PICK_SWEEP_RAMP_EN and STEP=1, 64 CW ticks from 600: steps 1×16, 2×16, 4×32, giving PickX=600+16+32+128=776.
